// File: rtl/phy_ready_table.sv
// Per-physical-register ready table: feedback sets entries, rename allocation clears them,
// flush marks everything ready. Queries forward same-cycle feedback.
module phy_ready_table #(
   parameter int unsigned PHY_REG_NUM          = 64,
   parameter int unsigned FEEDBACK_CHANNEL_NUM = 8,
   parameter int unsigned ALLOC_PORT_NUM       = 4,
   parameter int unsigned QUERY_PORT_NUM       = 8,
   parameter int unsigned VALUE_W              = 32,
   parameter int unsigned PHY_ID_W             = $clog2(PHY_REG_NUM),
   parameter int unsigned CNT_W                = $clog2(PHY_REG_NUM + 1),
   parameter int unsigned FB_W                 = 1 + PHY_ID_W + VALUE_W
) (
   input  logic                                          clk,
   input  logic                                          rst,
   // Each channel packs {enable, phy_id, value}, MSB first.
   input  logic [FEEDBACK_CHANNEL_NUM-1:0][FB_W-1:0]     execute_feedback_pack,
   input  logic [ALLOC_PORT_NUM-1:0]                     alloc_valid,
   input  logic [ALLOC_PORT_NUM-1:0][PHY_ID_W-1:0]       alloc_phy_id,
   input  logic                                          flush,
   input  logic [QUERY_PORT_NUM-1:0][PHY_ID_W-1:0]       query_phy_id,
   output logic [QUERY_PORT_NUM-1:0]                     query_ready,
   output logic [CNT_W-1:0]                              busy_count,
   output logic                                          protocol_error
);

   typedef struct packed {
      logic                enable;
      logic [PHY_ID_W-1:0] phy_id;
      logic [VALUE_W-1:0]  value;
   } fb_chan_t;

   fb_chan_t [FEEDBACK_CHANNEL_NUM-1:0] fb;

   logic [PHY_REG_NUM-1:0] ready_q, ready_d;
   logic [PHY_REG_NUM-1:0] fb_set;
   logic [PHY_REG_NUM-1:0] alloc_clr;
   logic [CNT_W-1:0]       busy_count_q, busy_count_d;
   logic                   protocol_error_q, protocol_error_d;
   logic                   fb_err;
   logic                   dup_err;
   logic                   unused_fb_value;

   assign fb = execute_feedback_pack;

   always_comb begin
      unused_fb_value = 1'b0;
      for (int c = 0; c < FEEDBACK_CHANNEL_NUM; c++) begin
         unused_fb_value = unused_fb_value ^ (^fb[c].value);
      end
   end

   // Duplicate feedback ids simply OR together here.
   always_comb begin
      fb_set = '0;
      for (int c = 0; c < FEEDBACK_CHANNEL_NUM; c++) begin
         if (fb[c].enable) begin
            fb_set[fb[c].phy_id] = 1'b1;
         end
      end
   end

   always_comb begin
      alloc_clr = '0;
      for (int p = 0; p < ALLOC_PORT_NUM; p++) begin
         if (alloc_valid[p]) begin
            alloc_clr[alloc_phy_id[p]] = 1'b1;
         end
      end
      alloc_clr[0] = 1'b0;
   end

   // Priority per entry: flush, then allocation clear, then feedback set.
   always_comb begin
      if (flush) begin
         ready_d = '1;
      end else begin
         ready_d = (ready_q | fb_set) & ~alloc_clr;
      end
      ready_d[0] = 1'b1;
   end

   always_comb begin
      busy_count_d = '0;
      for (int i = 0; i < PHY_REG_NUM; i++) begin
         busy_count_d = busy_count_d + CNT_W'(~ready_d[i]);
      end
   end

   always_comb begin
      fb_err = 1'b0;
      for (int c = 0; c < FEEDBACK_CHANNEL_NUM; c++) begin
         if (fb[c].enable && (fb[c].phy_id != '0) && ready_q[fb[c].phy_id] &&
             !alloc_clr[fb[c].phy_id]) begin
            fb_err = 1'b1;
         end
      end
   end

   always_comb begin
      dup_err = 1'b0;
      for (int i = 0; i < ALLOC_PORT_NUM; i++) begin
         for (int j = i + 1; j < ALLOC_PORT_NUM; j++) begin
            if (alloc_valid[i] && alloc_valid[j] && (alloc_phy_id[i] == alloc_phy_id[j]) &&
                (alloc_phy_id[i] != '0)) begin
               dup_err = 1'b1;
            end
         end
      end
   end

   assign protocol_error_d = protocol_error_q | fb_err | dup_err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         ready_q          <= '1;
         busy_count_q     <= '0;
         protocol_error_q <= 1'b0;
      end else begin
         ready_q          <= ready_d;
         busy_count_q     <= busy_count_d;
         protocol_error_q <= protocol_error_d;
      end
   end

   // Same-cycle allocation deliberately does not mask the answer.
   always_comb begin
      query_ready = '0;
      for (int q = 0; q < QUERY_PORT_NUM; q++) begin
         query_ready[q] = ready_q[query_phy_id[q]] | fb_set[query_phy_id[q]];
      end
   end

   assign busy_count     = busy_count_q;
   assign protocol_error = protocol_error_q;

endmodule

// File: tb/tb_phy_ready_table.sv
// Scoreboard bench for phy_ready_table: stimulus pushes expectations tagged with a cycle,
// a negedge monitor pops and compares them.
module tb_phy_ready_table;

   localparam int PHY_ID_W = 6;
   localparam int CNT_W    = 7;
   localparam int FB_W     = 1 + PHY_ID_W + 32;
   localparam int NFB      = 8;
   localparam int NAL      = 4;
   localparam int NQ       = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [NFB-1:0][FB_W-1:0]     execute_feedback_pack;
   logic [NAL-1:0]               alloc_valid;
   logic [NAL-1:0][PHY_ID_W-1:0] alloc_phy_id;
   logic                         flush;
   logic [NQ-1:0][PHY_ID_W-1:0]  query_phy_id;
   logic [NQ-1:0]                query_ready;
   logic [CNT_W-1:0]             busy_count;
   logic                         protocol_error;

   always #5 clk = ~clk;

   phy_ready_table dut (
      .clk                   (clk),
      .rst                   (rst),
      .execute_feedback_pack (execute_feedback_pack),
      .alloc_valid           (alloc_valid),
      .alloc_phy_id          (alloc_phy_id),
      .flush                 (flush),
      .query_phy_id          (query_phy_id),
      .query_ready           (query_ready),
      .busy_count            (busy_count),
      .protocol_error        (protocol_error)
   );

   typedef struct {
      int    kind;  // 0 query_ready[idx], 1 busy_count, 2 protocol_error
      int    idx;
      int    val;
      int    cyc;
      string name;
   } exp_t;

   exp_t sb[$];
   exp_t e_mon;
   int   cycle = 0;
   int   compared = 0;
   int   mismatched = 0;

   always @(posedge clk) cycle <= cycle + 1;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cycle) begin
         int got;
         e_mon = sb.pop_front();
         case (e_mon.kind)
            0:       got = int'(query_ready[e_mon.idx]);
            1:       got = int'(busy_count);
            default: got = int'(protocol_error);
         endcase
         compared++;
         if (got != e_mon.val || e_mon.cyc != cycle) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d/%0d)", e_mon.name, got,
                     e_mon.val, cycle, e_mon.cyc);
         end
      end
   end

   task automatic idle();
      execute_feedback_pack = '0;
      alloc_valid           = '0;
      alloc_phy_id          = '0;
      flush                 = 1'b0;
      query_phy_id          = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fb_on(input int ch, input int id);
      execute_feedback_pack[ch] = {1'b1, PHY_ID_W'(id), 32'hdead_beef};
   endtask

   task automatic alloc(input int p, input int id);
      alloc_valid[p]  = 1'b1;
      alloc_phy_id[p] = PHY_ID_W'(id);
   endtask

   task automatic query(input int q, input int id, input int exp, input string nm);
      query_phy_id[q] = PHY_ID_W'(id);
      sb.push_back('{kind: 0, idx: q, val: exp, cyc: cycle, name: nm});
   endtask

   task automatic exp_busy(input int v, input string nm);
      sb.push_back('{kind: 1, idx: 0, val: v, cyc: cycle, name: nm});
   endtask

   task automatic exp_err(input int v, input string nm);
      sb.push_back('{kind: 2, idx: 0, val: v, cyc: cycle, name: nm});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      tick();
      // Still in reset: table reads all ones.
      for (int q = 0; q < NQ; q++) query(q, q, 1, "in_reset_query");
      exp_busy(0, "in_reset_busy");
      exp_err(0, "in_reset_err");
      tick();
      rst = 1'b1;
      for (int g = 0; g < 8; g++) begin
         for (int q = 0; q < NQ; q++) query(q, g * 8 + q, 1, "reset_sweep_query");
         exp_busy(0, "reset_busy");
         exp_err(0, "reset_err");
         tick();
      end

      // Allocate 5..8, then feedback 6 on channel 2.
      idle();
      for (int p = 0; p < 4; p++) alloc(p, 5 + p);
      tick();
      idle();
      for (int q = 0; q < 4; q++) query(q, 5 + q, 0, "alloc_5_8_busy");
      exp_busy(4, "busy_after_alloc4");
      tick();
      idle();
      fb_on(2, 6);
      query(0, 6, 1, "fb6_forward");
      query(1, 5, 0, "phy5_still_busy");
      exp_busy(4, "busy_during_fb6");
      tick();
      idle();
      exp_busy(3, "busy_after_fb6");
      query(0, 6, 1, "phy6_table_ready");
      exp_err(0, "err_after_fb6");

      // Same-cycle allocate and feedback of 9.
      alloc(0, 9);
      fb_on(0, 9);
      query(1, 9, 1, "phy9_query_ignores_alloc");
      tick();
      idle();
      query(0, 9, 0, "phy9_ends_busy");
      exp_busy(4, "busy_after_alloc_fb9");
      exp_err(0, "err_alloc_fb_same");
      alloc(0, 0);
      tick();
      idle();
      exp_busy(4, "busy_alloc_phy0_ignored");
      query(0, 0, 1, "phy0_ready");
      exp_err(0, "err_alloc_phy0");

      // Duplicate feedback on busy 12, then illegal feedback to ready 13.
      alloc(0, 12);
      tick();
      idle();
      exp_busy(5, "busy_after_alloc12");
      fb_on(0, 12);
      fb_on(7, 12);
      query(0, 12, 1, "fb12_forward");
      tick();
      idle();
      exp_busy(4, "busy_after_fb12");
      exp_err(0, "err_dup_fb12");
      query(0, 12, 1, "phy12_ready");
      fb_on(3, 13);
      tick();
      idle();
      exp_err(1, "err_fb13_set");
      tick();
      exp_err(1, "err_sticky");

      // Grow to 20 busy, then flush alongside an allocation of 30.
      for (int c = 0; c < 4; c++) begin
         idle();
         for (int p = 0; p < 4; p++) alloc(p, 20 + c * 4 + p);
         tick();
      end
      idle();
      exp_busy(20, "busy_20");
      query(0, 30, 0, "phy30_busy_pre_flush");
      flush = 1'b1;
      alloc(0, 30);
      tick();
      idle();
      exp_busy(0, "busy_after_flush");
      query(0, 30, 1, "phy30_ready_after_flush");
      query(1, 5, 1, "phy5_ready_after_flush");
      query(2, 35, 1, "phy35_ready_after_flush");
      exp_err(1, "err_survives_flush");

      // Ten busy, then reset with alloc/feedback active.
      tick();
      for (int c = 0; c < 3; c++) begin
         idle();
         for (int p = 0; p < 4; p++) if (c * 4 + p < 10) alloc(p, 40 + c * 4 + p);
         tick();
      end
      idle();
      exp_busy(10, "busy_10");
      rst = 1'b0;
      alloc(0, 50);
      fb_on(1, 41);
      flush = 1'b1;
      tick();
      rst = 1'b1;
      idle();
      exp_busy(0, "busy_after_midreset");
      exp_err(0, "err_after_midreset");
      for (int q = 0; q < 7; q++) query(q, 40 + q, 1, "ready_after_midreset");
      query(7, 50, 1, "phy50_ready_after_midreset");

      // Two ports naming phy 0 is legal; two naming 55 is not.
      alloc(0, 0);
      alloc(1, 0);
      tick();
      idle();
      exp_err(0, "err_dup_alloc_phy0");
      exp_busy(0, "busy_dup_alloc_phy0");
      alloc(0, 55);
      alloc(1, 55);
      tick();
      idle();
      exp_err(1, "err_dup_alloc55");
      exp_busy(1, "busy_dup_alloc55");
      query(0, 55, 0, "phy55_busy");
      flush = 1'b1;
      tick();
      idle();
      exp_busy(0, "busy_flush_again");

      // Fill every non-zero entry.
      for (int c = 0; c < 16; c++) begin
         idle();
         for (int p = 0; p < 4; p++) if (1 + c * 4 + p <= 63) alloc(p, 1 + c * 4 + p);
         tick();
      end
      idle();
      exp_busy(63, "busy_all_63");
      query(0, 0, 1, "phy0_ready_full");
      query(1, 1, 0, "phy1_busy_full");
      query(2, 63, 0, "phy63_busy_full");
      tick();
      idle();
      fb_on(5, 63);
      query(0, 63, 1, "fb63_forward");
      exp_busy(63, "busy_all_63_hold");
      tick();
      idle();
      exp_busy(62, "busy_after_fb63");
      query(0, 63, 1, "phy63_table_ready");

      tick();
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         mismatched++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/phy_ready_table.md
# phy_ready_table

Per-physical-register ready tracker and the receiving end of the execute feedback path. Consumes `execute_feedback_pack` each cycle and marks written physical registers ready. Clears entries when rename allocates new destinations. Answers operand-ready queries from rename/issue, including same-cycle forwarding of feedback.

## Interface

Parameters:
- `PHY_REG_NUM`, 64 — number of physical registers; `PHY_ID_W = $clog2(PHY_REG_NUM)`.
- `FEEDBACK_CHANNEL_NUM`, 8 — channels in `execute_feedback_pack` (sum of all execute unit counts).
- `ALLOC_PORT_NUM`, 4 — rename allocation ports per cycle.
- `QUERY_PORT_NUM`, 8 — ready query ports.

Ports:
- `clk` in 1 — clock; single clock domain.
- `rst` in 1 — synchronous, active-low reset.
- `execute_feedback_pack` in `execute_feedback_pack_t` — per channel: `enable`, `phy_id`, `value`. `value` is ignored.
- `alloc_valid` in `ALLOC_PORT_NUM` — allocation port valid.
- `alloc_phy_id` in `ALLOC_PORT_NUM×PHY_ID_W` — newly allocated destination.
- `flush` in 1 — pipeline flush.
- `query_phy_id` in `QUERY_PORT_NUM×PHY_ID_W` — source operand to test.
- `query_ready` out `QUERY_PORT_NUM` — operand ready, with same-cycle forwarding.
- `busy_count` out `$clog2(PHY_REG_NUM+1)` — number of not-ready registers (registered).
- `protocol_error` out 1 — sticky; set by an illegal feedback.

## Operation

- State:
  - `ready[PHY_REG_NUM]`.
  - `busy_count` register.
  - `protocol_error` register.
- Entry 0 is hardwired ready:
  - Allocation of phy 0 is ignored.
  - Feedback to phy 0 is ignored and does not trigger an error.
- Feedback: for every channel with `enable=1`, `ready[phy_id]` ← 1 at the next edge. Duplicate phy_ids across channels are OR-ed.
- Allocation: for every port with `alloc_valid=1`, `ready[alloc_phy_id]` ← 0 at the next edge.
- Priority per entry: `flush` > allocation clear > feedback set.
- Flush: all entries ← 1 at the next edge.
  - Rationale: committed mappings are already ready, and squashed destinations are re-cleared when reallocated.
  - `busy_count` ← 0.
  - Same-cycle allocations and feedback are discarded.
- Query (combinational): `query_ready[q] = ready[query_phy_id[q]] | (any enabled feedback channel with phy_id == query_phy_id[q])`.
  - Same-cycle allocation does NOT affect the query result. Rename resolves intra-group dependencies itself.
- `busy_count`: registered popcount of `~ready` after the update, i.e. it equals the popcount of next-state `ready`'s zeros.
- `protocol_error` is set (sticky until reset) when either of these holds:
  - An enabled feedback channel targets an entry that is already ready and not being cleared in that cycle.
  - Two allocation ports name the same non-zero phy in one cycle.

## Timing

- Reset (`rst=0` at an edge):
  - `ready` all 1.
  - `busy_count` = 0.
  - `protocol_error` = 0.
  - While in reset, `query_ready` reflects the table, which holds all ones.
- Reset mid-operation wins over flush, alloc and feedback in the same cycle.
- Latency:
  - Feedback → `query_ready`: 0 cycles (forward path), and stays set from the next cycle via the table.
  - Allocation → `query_ready` low: 1 cycle.
  - Any update → `busy_count`: 1 cycle.
- Boundary cases:
  - All `PHY_REG_NUM-1` entries busy → `busy_count = PHY_REG_NUM-1`, with no overflow.
  - Allocation and feedback to the same phy in the same cycle: the entry ends busy; the feedback is not an error.
  - Feedback to a busy entry with an enabled query on the same phy in the same cycle: `query_ready=1`.
- No backpressure: every input is accepted in the cycle it is presented.

## Test plan

- Reset then query phys 0..63 → all `query_ready=1`, `busy_count=0`, `protocol_error=0`.
- Allocate phys 5,6,7,8 in one cycle → next cycle: queries on 5..8 = 0, `busy_count=4`. Feedback on phy 6 (channel 2) → same-cycle query on 6 = 1; next cycle `busy_count=3`.
- Allocate phy 9 and feed back phy 9 in the same cycle → phy 9 busy, `busy_count` increments by 1, no error. Allocate phy 0 → ignored, `busy_count` unchanged.
- Feedback on phy 12 from channels 0 and 7 with phy 12 busy → ready, `busy_count` −1, no error. Feedback on already-ready phy 13 → `protocol_error=1`, which stays 1 until reset.
- 20 entries busy, then `flush` together with allocation of phy 30 → next cycle all ready, `busy_count=0`, phy 30 ready.
- Drive `rst=0` for one cycle while 10 entries are busy and allocation/feedback are active → next cycle all ready, `busy_count=0`, `protocol_error=0`.
